// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl
// MMIO register block sitting beside the core's data memory port. It decodes
// loads/stores in the 0x8xxx_xxxx window, buffers one received UART byte,
// holds one byte for the UART transmitter, and keeps cycle/instruction
// counters. Load data is registered so it lines up with sync-read memories
// in the writeback stage.
module mmio_uart_ctrl #(
  parameter logic [3:0]  MMIO_NIBBLE = 4'h8,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  input  logic        inst_retire,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h10;
  localparam logic [7:0] OFF_INSTS  = 8'h14;
  localparam logic [7:0] OFF_CNTCLR = 8'h18;

  logic [7:0]           r_rx_buf;
  logic                 r_rx_full;
  logic [7:0]           r_tx_data;
  logic                 r_tx_busy;
  logic                 r_tx_ovf;
  logic [CNT_WIDTH-1:0] r_cycles;
  logic [CNT_WIDTH-1:0] r_insts;
  logic [31:0]          r_mem_rdata;

  logic                 w_sel;
  logic [7:0]           w_off;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_rx_take;
  logic                 w_rx_pop;
  logic                 w_tx_wr;
  logic                 w_ctrl_clr;
  logic                 w_cnt_clr;
  logic [31:0]          w_cycles_ext;
  logic [31:0]          w_insts_ext;
  logic [31:0]          w_map;
  logic                 w_unused;

  // Address decode: only the top nibble selects the block, the low byte picks
  // the register, everything in between is don't-care.
  assign w_sel = (mem_addr[31:28] == MMIO_NIBBLE);
  assign w_off = mem_addr[7:0];
  assign w_rd  = w_sel & mem_re;
  assign w_wr  = w_sel & mem_we;

  assign w_unused = ^{mem_addr[27:8], mem_wdata[31:8]};

  // The receiver is only told we are ready when the holding register is empty,
  // so a capture and a pop can never land on the same edge.
  assign w_rx_take  = rx_valid & ~r_rx_full;
  assign w_rx_pop   = w_rd & (w_off == OFF_RXDATA) & r_rx_full;
  assign w_tx_wr    = w_wr & (w_off == OFF_TXDATA);
  assign w_ctrl_clr = w_wr & (w_off == OFF_CTRL) & mem_wdata[2];
  assign w_cnt_clr  = w_wr & (w_off == OFF_CNTCLR);

  assign rx_ready  = ~r_rx_full;
  assign tx_valid  = r_tx_busy;
  assign tx_data   = r_tx_data;
  assign mem_rdata = r_mem_rdata;

  // Zero-extend the counters to the 32-bit bus and select the addressed register.
  // NOTE: every variable in this always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_cycles_ext                  = '0;
    w_insts_ext                   = '0;
    w_cycles_ext[CNT_WIDTH-1:0]   = r_cycles;
    w_insts_ext[CNT_WIDTH-1:0]    = r_insts;
    w_map                         = '0;
    case (w_off)
      OFF_CTRL:   w_map = {29'b0, r_tx_ovf, r_rx_full, ~r_tx_busy};
      OFF_RXDATA: w_map = {24'b0, r_rx_buf};
      OFF_CYCLES: w_map = w_cycles_ext;
      OFF_INSTS:  w_map = w_insts_ext;
      default:    w_map = '0;
    endcase
  end

  // Registered load data: the map is sampled with the state as it was before
  // this edge's updates, and the bus is driven to 0 when nothing is read.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_rdata <= '0;
    end else if (w_rd) begin
      r_mem_rdata <= w_map;
    end else begin
      r_mem_rdata <= '0;
    end
  end

  // RX holding register: capture on handshake, drop the full flag on an RXDATA read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_buf  <= '0;
      r_rx_full <= 1'b0;
    end else if (w_rx_take) begin
      r_rx_buf  <= rx_data;
      r_rx_full <= 1'b1;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end

  // TX register: accept a byte only when idle; a handshake frees it. A write
  // that arrives while busy is dropped even if the handshake completes now.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data <= '0;
      r_tx_busy <= 1'b0;
    end else if (w_tx_wr && !r_tx_busy) begin
      r_tx_data <= mem_wdata[7:0];
      r_tx_busy <= 1'b1;
    end else if (r_tx_busy && tx_ready) begin
      r_tx_busy <= 1'b0;
    end
  end

  // Sticky overflow flag: a fresh overflow beats a same-cycle software clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_ovf <= 1'b0;
    end else if (w_tx_wr && r_tx_busy) begin
      r_tx_ovf <= 1'b1;
    end else if (w_ctrl_clr) begin
      r_tx_ovf <= 1'b0;
    end
  end

  // Free-running cycle counter and retired-instruction counter; a CNTCLR
  // write zeroes both and takes priority over this cycle's increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycles <= '0;
      r_insts  <= '0;
    end else if (w_cnt_clr) begin
      r_cycles <= '0;
      r_insts  <= '0;
    end else begin
      r_cycles <= r_cycles + CNT_WIDTH'(1);
      if (inst_retire) begin
        r_insts <= r_insts + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl
// Directed bench for mmio_uart_ctrl. A second instance with 4-bit counters
// shares all inputs so counter wrap-around can be observed in a short run.
module tb_mmio_uart_ctrl;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h10;
  localparam logic [7:0] OFF_INSTS  = 8'h14;
  localparam logic [7:0] OFF_CNTCLR = 8'h18;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic        inst_retire = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;

  logic [31:0] mem_rdata;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;

  logic [31:0] mem_rdata_w4;
  logic        rx_ready_w4;
  logic [7:0]  tx_data_w4;
  logic        tx_valid_w4;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdata;

  mmio_uart_ctrl #(.MMIO_NIBBLE(4'h8), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .inst_retire(inst_retire), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  mmio_uart_ctrl #(.MMIO_NIBBLE(4'h8), .CNT_WIDTH(4)) u_dut_w4 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata_w4),
    .inst_retire(inst_retire), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_w4), .tx_data(tx_data_w4), .tx_valid(tx_valid_w4),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_addr(input logic [31:0] addr, output logic [31:0] data);
    mem_addr  = addr;
    mem_wdata = '0;
    mem_re    = 1'b1;
    tick();
    mem_re    = 1'b0;
    data      = mem_rdata;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] data);
    rd_addr({4'h8, 20'h0, off}, data);
  endtask

  task automatic wr_addr(input logic [31:0] addr, input logic [31:0] data);
    mem_addr  = addr;
    mem_wdata = data;
    mem_we    = 1'b1;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    wr_addr({4'h8, 20'h0, off}, data);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    // 1. Reset values, then CTRL after release.
    #1;
    check("reset_rdata",    mem_rdata, 32'h0);
    check("reset_rx_ready", {31'b0, rx_ready}, 32'h1);
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    rd(OFF_CTRL, rdata);
    check("ctrl_after_reset", rdata, 32'h1);
    check("rx_ready_idle", {31'b0, rx_ready}, 32'h1);
    check("tx_valid_idle", {31'b0, tx_valid}, 32'h0);

    // 2. RX capture, back-pressure while full, pop, stale read.
    rx_push(8'h5A);
    check("rx_ready_full", {31'b0, rx_ready}, 32'h0);
    rd(OFF_CTRL, rdata);
    check("ctrl_rx_full", rdata, 32'h3);
    rx_push(8'hA5);
    rd(OFF_RXDATA, rdata);
    check("rxdata", rdata, 32'h5A);
    check("rx_ready_after_pop", {31'b0, rx_ready}, 32'h1);
    rd(OFF_CTRL, rdata);
    check("ctrl_after_pop", rdata, 32'h1);
    rd(OFF_RXDATA, rdata);
    check("rxdata_stale", rdata, 32'h5A);
    check("rx_ready_stale", {31'b0, rx_ready}, 32'h1);

    // 3. TX load, overflow, handshake, overflow clear.
    tx_ready = 1'b0;
    wr(OFF_TXDATA, 32'h41);
    check("tx_valid_load", {31'b0, tx_valid}, 32'h1);
    check("tx_data_load", {24'b0, tx_data}, 32'h41);
    wr(OFF_TXDATA, 32'h42);
    check("tx_data_kept", {24'b0, tx_data}, 32'h41);
    rd(OFF_CTRL, rdata);
    check("ctrl_ovf_busy", rdata, 32'h4);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("tx_valid_done", {31'b0, tx_valid}, 32'h0);
    rd(OFF_CTRL, rdata);
    check("ctrl_ovf_idle", rdata, 32'h5);
    wr(OFF_CTRL, 32'h4);
    rd(OFF_CTRL, rdata);
    check("ctrl_ovf_cleared", rdata, 32'h1);

    // Overflow write coinciding with a completing handshake.
    wr(OFF_TXDATA, 32'h43);
    tx_ready = 1'b1;
    wr(OFF_TXDATA, 32'h44);
    tx_ready = 1'b0;
    check("tx_valid_ovf_hs", {31'b0, tx_valid}, 32'h0);
    check("tx_data_ovf_hs", {24'b0, tx_data}, 32'h43);

    // Simultaneous read and clear of CTRL returns pre-write state.
    mem_addr  = {4'h8, 20'h0, OFF_CTRL};
    mem_wdata = 32'h4;
    mem_we    = 1'b1;
    mem_re    = 1'b1;
    tick();
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    check("ctrl_rw_same", mem_rdata, 32'h5);
    rd(OFF_CTRL, rdata);
    check("ctrl_after_rw", rdata, 32'h1);

    // 4. Counters: 100 cycles, 37 with a retirement.
    wr(OFF_CNTCLR, 32'h0);
    for (int i = 0; i < 100; i++) begin
      inst_retire = (((i * 7) % 100) < 37);
      tick();
    end
    inst_retire = 1'b0;
    rd(OFF_CYCLES, rdata);
    check("cycles_100", rdata, 32'd100);
    check("cycles_100_w4", mem_rdata_w4, 32'd4);
    rd(OFF_INSTS, rdata);
    check("insts_37", rdata, 32'd37);
    check("insts_37_w4", mem_rdata_w4, 32'd5);

    wr(OFF_CNTCLR, 32'h0);
    tick();
    rd(OFF_CYCLES, rdata);
    check("cycles_after_clr", rdata, 32'd1);
    rd(OFF_INSTS, rdata);
    check("insts_after_clr", rdata, 32'd0);

    // 5. Wrap on the 4-bit instance, reference values on the 32-bit one.
    wr(OFF_CNTCLR, 32'h0);
    repeat (14) tick();
    rd(OFF_CYCLES, rdata);
    check("wrap_w4_e", mem_rdata_w4, 32'hE);
    check("wrap_w32_e", rdata, 32'd14);
    rd(OFF_CYCLES, rdata);
    check("wrap_w4_f", mem_rdata_w4, 32'hF);
    check("wrap_w32_f", rdata, 32'd15);
    rd(OFF_CYCLES, rdata);
    check("wrap_w4_0", mem_rdata_w4, 32'h0);
    check("wrap_w32_10", rdata, 32'd16);

    // Unselected and unmapped accesses.
    rx_push(8'h77);
    rd_addr(32'h1000_0004, rdata);
    check("unsel_rdata", rdata, 32'h0);
    check("unsel_no_pop", {31'b0, rx_ready}, 32'h0);
    wr_addr(32'h1000_0008, 32'h99);
    check("unsel_no_tx", {31'b0, tx_valid}, 32'h0);
    rd(8'h0C, rdata);
    check("unmapped_rdata", rdata, 32'h0);
    rd_addr(32'h8ABC_DE04, rdata);
    check("mid_bits_ignored", rdata, 32'h77);
    check("mid_bits_pop", {31'b0, rx_ready}, 32'h1);

    // 6. Asynchronous reset with TX pending and RX full.
    wr(OFF_TXDATA, 32'h55);
    rx_push(8'h66);
    rd(OFF_CTRL, rdata);
    check("ctrl_busy_full", rdata, 32'h2);
    #2 rst = 1'b0;
    #1;
    check("arst_rx_ready", {31'b0, rx_ready}, 32'h1);
    check("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("arst_tx_data", {24'b0, tx_data}, 32'h0);
    check("arst_rdata", mem_rdata, 32'h0);
    check("arst_w4_rx_ready", {31'b0, rx_ready_w4}, 32'h1);
    check("arst_w4_tx_valid", {31'b0, tx_valid_w4}, 32'h0);
    check("arst_w4_tx_data", {24'b0, tx_data_w4}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    rd(OFF_RXDATA, rdata);
    check("rxbuf_cleared", rdata, 32'h0);
    rd(OFF_CTRL, rdata);
    check("ctrl_after_arst", rdata, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
